// File: rtl/pmod_7seg9_3.sv
// TM1640 demo driver: BCD down counter and up counter shown as [dddd]-[uuuu]
// on a 9-digit 7-segment PMOD, refreshed on every 10 Hz count tick.
module pmod_7seg9_3 #(
  parameter int         CLK_FREQ = 100_000_000,
  parameter int         TM_DIV   = 2,
  parameter logic [2:0] BRIGHT   = 3'd7
) (
  input  logic clk,
  input  logic rst,
  output logic tm_clk,
  output logic tm_din,
  output logic debug_led
);

  localparam int TICK_N = CLK_FREQ / 10;
  localparam int TICK_W = (TICK_N > 1) ? $clog2(TICK_N) : 1;
  localparam int DIV_W  = (TM_DIV > 1) ? $clog2(TM_DIV) : 1;
  localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(TICK_N - 1);
  localparam logic [DIV_W-1:0]  DIV_LAST  = DIV_W'(TM_DIV - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_START, S_BIT_LO, S_BIT_HI, S_STOP_LO, S_STOP_HI, S_STOP_END
  } state_t;

  logic [TICK_W-1:0] tick_cnt;
  logic              tick;
  logic [3:0]        u_th, u_hu, u_te, u_on;
  logic [3:0]        d_th, d_hu, d_te, d_on;

  state_t            state;
  logic              pending;
  logic [DIV_W-1:0]  div_cnt;
  logic [1:0]        tx;
  logic [3:0]        byte_idx;
  logic [2:0]        bit_idx;
  logic [31:0]       snap;
  logic [7:0]        cur_byte, nxt_byte;
  logic [3:0]        last_idx;
  logic              step_done;

  function automatic logic [7:0] seg(input logic [3:0] v);
    logic [7:0] s;
    case (v)
      4'd0: s = 8'h3F;
      4'd1: s = 8'h06;
      4'd2: s = 8'h5B;
      4'd3: s = 8'h4F;
      4'd4: s = 8'h66;
      4'd5: s = 8'h6D;
      4'd6: s = 8'h7D;
      4'd7: s = 8'h07;
      4'd8: s = 8'h7F;
      4'd9: s = 8'h6F;
      default: s = 8'h00;
    endcase
    return s;
  endfunction

  // Byte idx of transaction t: T1 data command, T2 address + 9 digits, T3 display control
  function automatic logic [7:0] frame_byte(input logic [1:0] t, input logic [3:0] idx,
                                            input logic [31:0] s);
    logic [7:0] b;
    b = 8'h00;
    if (t == 2'd0) b = 8'h40;
    else if (t == 2'd2) b = 8'h88 | {5'd0, BRIGHT};
    else begin
      case (idx)
        4'd0: b = 8'hC0;
        4'd1: b = seg(s[31:28]);
        4'd2: b = seg(s[27:24]);
        4'd3: b = seg(s[23:20]);
        4'd4: b = seg(s[19:16]);
        4'd5: b = 8'h40;
        4'd6: b = seg(s[15:12]);
        4'd7: b = seg(s[11:8]);
        4'd8: b = seg(s[7:4]);
        4'd9: b = seg(s[3:0]);
        default: b = 8'h00;
      endcase
    end
    return b;
  endfunction

  assign tick      = (tick_cnt == TICK_LAST);
  assign step_done = (div_cnt == DIV_LAST);
  assign cur_byte  = frame_byte(tx, byte_idx, snap);
  assign nxt_byte  = frame_byte(tx, byte_idx + 4'd1, snap);
  assign last_idx  = (tx == 2'd1) ? 4'd9 : 4'd0;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      tick_cnt  <= '0;
      debug_led <= 1'b0;
      {u_th, u_hu, u_te, u_on} <= 16'h0000;
      {d_th, d_hu, d_te, d_on} <= 16'h9999;
    end else if (tick) begin
      tick_cnt  <= '0;
      debug_led <= ~debug_led;
      // BCD ripple carry on the up counter
      if (u_on != 4'd9) u_on <= u_on + 4'd1;
      else begin
        u_on <= 4'd0;
        if (u_te != 4'd9) u_te <= u_te + 4'd1;
        else begin
          u_te <= 4'd0;
          if (u_hu != 4'd9) u_hu <= u_hu + 4'd1;
          else begin
            u_hu <= 4'd0;
            u_th <= (u_th != 4'd9) ? u_th + 4'd1 : 4'd0;
          end
        end
      end
      // BCD ripple borrow on the down counter
      if (d_on != 4'd0) d_on <= d_on - 4'd1;
      else begin
        d_on <= 4'd9;
        if (d_te != 4'd0) d_te <= d_te - 4'd1;
        else begin
          d_te <= 4'd9;
          if (d_hu != 4'd0) d_hu <= d_hu - 4'd1;
          else begin
            d_hu <= 4'd9;
            d_th <= (d_th != 4'd0) ? d_th - 4'd1 : 4'd9;
          end
        end
      end
    end else begin
      tick_cnt <= tick_cnt + 1'b1;
    end
  end

  // Each line step is held for TM_DIV clocks; outputs change only on step transitions
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= S_IDLE;
      pending  <= 1'b1;
      tm_clk   <= 1'b1;
      tm_din   <= 1'b1;
      div_cnt  <= '0;
      tx       <= 2'd0;
      byte_idx <= 4'd0;
      bit_idx  <= 3'd0;
      snap     <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          div_cnt <= '0;
          if (pending) begin
            pending  <= 1'b0;
            snap     <= {d_th, d_hu, d_te, d_on, u_th, u_hu, u_te, u_on};
            tx       <= 2'd0;
            byte_idx <= 4'd0;
            tm_din   <= 1'b0;
            state    <= S_START;
          end
        end
        default: begin
          if (!step_done) div_cnt <= div_cnt + 1'b1;
          else begin
            div_cnt <= '0;
            case (state)
              S_START: begin
                bit_idx <= 3'd0;
                tm_clk  <= 1'b0;
                tm_din  <= cur_byte[0];
                state   <= S_BIT_LO;
              end
              S_BIT_LO: begin
                tm_clk <= 1'b1;
                state  <= S_BIT_HI;
              end
              S_BIT_HI: begin
                tm_clk <= 1'b0;
                if (bit_idx != 3'd7) begin
                  bit_idx <= bit_idx + 3'd1;
                  tm_din  <= cur_byte[bit_idx + 3'd1];
                  state   <= S_BIT_LO;
                end else if (byte_idx != last_idx) begin
                  byte_idx <= byte_idx + 4'd1;
                  bit_idx  <= 3'd0;
                  tm_din   <= nxt_byte[0];
                  state    <= S_BIT_LO;
                end else begin
                  tm_din <= 1'b0;
                  state  <= S_STOP_LO;
                end
              end
              S_STOP_LO: begin
                tm_clk <= 1'b1;
                state  <= S_STOP_HI;
              end
              S_STOP_HI: begin
                tm_din <= 1'b1;
                state  <= S_STOP_END;
              end
              S_STOP_END: begin
                if (tx == 2'd2) state <= S_IDLE;
                else begin
                  tx       <= tx + 2'd1;
                  byte_idx <= 4'd0;
                  tm_din   <= 1'b0;
                  state    <= S_START;
                end
              end
              default: state <= S_IDLE;
            endcase
          end
        end
      endcase
      // A tick always wins over the frame start clearing the flag
      if (tick) pending <= 1'b1;
    end
  end

endmodule

// File: tb/tb_pmod_7seg9_3.sv
// Bench for pmod_7seg9_3: decodes the TM1640 line protocol into frames and
// checks BCD counters, frame bytes, wrap-around and mid-frame reset.
module tb_pmod_7seg9_3;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic tm_clk, tm_din, debug_led;
  logic tm_clk2, tm_din2, debug_led2;

  int num_checks = 0;
  int num_errors = 0;
  int cyc = 0;

  logic       prev_clk = 1'b1, prev_din = 1'b1, in_tx = 1'b0;
  int         bit_cnt = 0, starts = 0, stops = 0, viol = 0;
  logic [7:0] shreg = 8'h00;
  logic [7:0] rx_q[$];
  logic [7:0] last_frame[12];
  int         last_len = 0, last_starts = 0, last_stops = 0, last_viol = 0;
  int         frames_done = 0;

  pmod_7seg9_3 #(.CLK_FREQ(20_000), .TM_DIV(2), .BRIGHT(3'd7)) dut (
    .clk(clk), .rst(rst), .tm_clk(tm_clk), .tm_din(tm_din), .debug_led(debug_led)
  );

  // Fast-ticking copy used to reach the 9999/0000 wrap in few clocks
  pmod_7seg9_3 #(.CLK_FREQ(20), .TM_DIV(1), .BRIGHT(3'd7)) dut2 (
    .clk(clk), .rst(rst), .tm_clk(tm_clk2), .tm_din(tm_din2), .debug_led(debug_led2)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (!rst) cyc <= 0;
    else cyc <= cyc + 1;
  end

  // Line decoder: START/STOP are DIN edges with CLK high, bits are CLK rising edges
  always @(negedge clk) begin
    if (!rst) begin
      in_tx = 1'b0; bit_cnt = 0; starts = 0; stops = 0; viol = 0;
      rx_q.delete();
      prev_clk = 1'b1; prev_din = 1'b1;
    end else begin
      if (prev_clk && tm_clk && prev_din && !tm_din) begin
        if (in_tx) viol++;
        in_tx = 1'b1; bit_cnt = 0; starts++;
      end else if (prev_clk && tm_clk && !prev_din && tm_din) begin
        if (!in_tx || bit_cnt != 1) viol++;
        in_tx = 1'b0; stops++;
        if (stops == 3) begin
          for (int i = 0; i < 12; i++) last_frame[i] = (i < rx_q.size()) ? rx_q[i] : 8'h00;
          last_len = rx_q.size(); last_starts = starts; last_stops = stops; last_viol = viol;
          rx_q.delete(); starts = 0; stops = 0; viol = 0;
          frames_done++;
        end
      end else if (!prev_clk && tm_clk) begin
        if (tm_din != prev_din) viol++;
        if (!in_tx) viol++;
        else begin
          shreg[bit_cnt[2:0]] = tm_din;
          bit_cnt++;
          if (bit_cnt == 8) begin
            rx_q.push_back(shreg);
            bit_cnt = 0;
          end
        end
      end
      prev_clk = tm_clk; prev_din = tm_din;
    end
  end

  function automatic logic [7:0] segOf(input int v);
    case (v)
      0: return 8'h3F;
      1: return 8'h06;
      2: return 8'h5B;
      3: return 8'h4F;
      4: return 8'h66;
      5: return 8'h6D;
      6: return 8'h7D;
      7: return 8'h07;
      8: return 8'h7F;
      9: return 8'h6F;
      default: return 8'h00;
    endcase
  endfunction

  function automatic logic [15:0] bcd4(input int v);
    return {4'(v / 1000 % 10), 4'(v / 100 % 10), 4'(v / 10 % 10), 4'(v % 10)};
  endfunction

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    num_checks++;
    if (got !== exp) begin
      num_errors++;
      $display("[TB] FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  task automatic applyStimulus(input logic rst_val);
    @(negedge clk);
    rst = rst_val;
  endtask

  task automatic waitCycle(input int target);
    while (cyc < target) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic waitNextFrame(input string tag);
    int start_cnt;
    int n;
    start_cnt = frames_done;
    n = 0;
    while (frames_done == start_cnt && n < 5000) begin
      @(posedge clk);
      n++;
    end
    #1;
    checkOutput({tag, "_done"}, {31'd0, frames_done != start_cnt}, 32'd1);
  endtask

  task automatic checkFrame(input string tag, input int dv, input int uv);
    logic [7:0] exp_b[12];
    exp_b[0] = 8'h40;
    exp_b[1] = 8'hC0;
    exp_b[2] = segOf(dv / 1000 % 10);
    exp_b[3] = segOf(dv / 100 % 10);
    exp_b[4] = segOf(dv / 10 % 10);
    exp_b[5] = segOf(dv % 10);
    exp_b[6] = 8'h40;
    exp_b[7] = segOf(uv / 1000 % 10);
    exp_b[8] = segOf(uv / 100 % 10);
    exp_b[9] = segOf(uv / 10 % 10);
    exp_b[10] = segOf(uv % 10);
    exp_b[11] = 8'h8F;
    checkOutput({tag, "_starts"}, last_starts, 32'd3);
    checkOutput({tag, "_stops"}, last_stops, 32'd3);
    checkOutput({tag, "_proto"}, last_viol, 32'd0);
    checkOutput({tag, "_len"}, last_len, 32'd12);
    for (int i = 0; i < 12; i++)
      checkOutput($sformatf("%s_b%0d", tag, i), {24'd0, last_frame[i]}, {24'd0, exp_b[i]});
  endtask

  task automatic checkCounts(input string tag, input bit fast, input int dv, input int uv);
    logic [15:0] gu, gd;
    if (fast) begin
      gu = {dut2.u_th, dut2.u_hu, dut2.u_te, dut2.u_on};
      gd = {dut2.d_th, dut2.d_hu, dut2.d_te, dut2.d_on};
    end else begin
      gu = {dut.u_th, dut.u_hu, dut.u_te, dut.u_on};
      gd = {dut.d_th, dut.d_hu, dut.d_te, dut.d_on};
    end
    checkOutput({tag, "_u"}, {16'd0, gu}, {16'd0, bcd4(uv)});
    checkOutput({tag, "_d"}, {16'd0, gd}, {16'd0, bcd4(dv)});
  endtask

  initial begin
    rst = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    checkOutput("rst_clk", {31'd0, tm_clk}, 32'd1);
    checkOutput("rst_din", {31'd0, tm_din}, 32'd1);
    checkOutput("rst_led", {31'd0, debug_led}, 32'd0);
    checkCounts("rst", 1'b0, 9999, 0);

    applyStimulus(1'b1);
    waitCycle(18);
    checkCounts("fast_t9", 1'b1, 9990, 9);
    waitCycle(20);
    checkCounts("fast_t10", 1'b1, 9989, 10);

    waitNextFrame("frame0");
    checkFrame("frame0", 9999, 0);

    waitCycle(1999);
    checkCounts("pre_tick1", 1'b0, 9999, 0);
    checkOutput("pre_tick1_led", {31'd0, debug_led}, 32'd0);
    waitCycle(2000);
    checkCounts("tick1", 1'b0, 9998, 1);
    checkOutput("tick1_led", {31'd0, debug_led}, 32'd1);
    waitNextFrame("frame1");
    checkFrame("frame1", 9998, 1);

    for (int t = 2; t <= 9; t++) begin
      waitCycle(2000 * t);
      checkCounts($sformatf("tick%0d", t), 1'b0, 9999 - t, t);
      checkOutput($sformatf("tick%0d_led", t), {31'd0, debug_led}, t % 2);
    end

    waitCycle(19998);
    checkCounts("fast_t9999", 1'b1, 0, 9999);
    waitCycle(20000);
    checkCounts("fast_wrap", 1'b1, 9999, 0);
    checkCounts("tick10", 1'b0, 9989, 10);
    waitNextFrame("frame10");
    checkFrame("frame10", 9989, 10);

    waitCycle(22100);
    @(negedge clk);
    rst = 1'b0;
    #1;
    checkOutput("midrst_clk", {31'd0, tm_clk}, 32'd1);
    checkOutput("midrst_din", {31'd0, tm_din}, 32'd1);
    checkOutput("midrst_led", {31'd0, debug_led}, 32'd0);
    checkCounts("midrst", 1'b0, 9999, 0);
    repeat (4) @(posedge clk);
    applyStimulus(1'b1);
    waitNextFrame("frame_rst");
    checkFrame("frame_rst", 9999, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", num_checks, num_errors);
    $finish;
  end

endmodule

// File: doc/pmod_7seg9_3.md
Name: pmod_7seg9_3

Overview:
- Demo driver for a 9-digit 7-segment PMOD built on a TM1640 LED controller, using a 2-wire CLK/DIN serial interface.
- Runs two 4-digit BCD counters: "d", a down counter, and "u", an up counter.
- Each count tick, it sends the full display frame: [d3 d2 d1 d0] - [u3 u2 u1 u0].
- Top-level block; only the clock/reset pins and the display pins are external.

Parameters:
- CLK_FREQ, 100_000_000: system clock frequency in Hz. A count tick occurs every CLK_FREQ/10 clocks (10 Hz).
- TM_DIV, 2: system clocks per tm_clk half-period. Must be ≥1.
- BRIGHT, 7: 3-bit brightness used in the display-control byte.

Ports:
- clk, input, 1: system clock; all logic on its rising edge.
- rst, input, 1: asynchronous, active-low reset.
- tm_clk, output, 1: TM1640 CLK; idle high.
- tm_din, output, 1: TM1640 DIN; idle high.
- debug_led, output, 1: toggles on every count tick.

Behaviour:
- Reset (rst=0, asynchronous):
  - tm_clk=1, tm_din=1, debug_led=0.
  - Tick counter cleared.
  - u_th/u_hu/u_te/u_on = 0,0,0,0.
  - d_th/d_hu/d_te/d_on = 9,9,9,9.
  - pending-frame flag = 1.
  - Any frame in progress is aborted immediately.
- Counter registers are 4-bit BCD named u_th, u_hu, u_te, u_on and d_th, d_hu, d_te, d_on. The bench probes these names hierarchically.
- Tick generation:
  - Counter runs 0..CLK_FREQ/10-1 and wraps.
  - On wrap: u increments with BCD ripple carry (ones 9→0 carries to tens, etc.); 9999 wraps to 0000.
  - On wrap: d decrements with BCD borrow; 0000 wraps to 9999.
  - On wrap: debug_led toggles and pending-frame is set.
- Frame engine, started when pending=1 and the engine is idle:
  - Clears pending and snapshots all 8 digits.
  - A tick during a frame sets pending again; that frame is sent right after the current one. Ticks are never lost, frames never overlap.
  - First frame is sent right after reset release.
- Frame content is three transactions, in order:
  - T1: START, 0x40 (data command, auto-increment), STOP.
  - T2: START, 0xC0 (address 0), then 9 data bytes, then STOP. Data bytes: seg(d_th), seg(d_hu), seg(d_te), seg(d_on), 0x40 (dash), seg(u_th), seg(u_hu), seg(u_te), seg(u_on).
  - T3: START, 0x88|BRIGHT (display on), STOP.
- Segment encoding, bit0=a … bit6=g, bit7=dp=0: 0=0x3F, 1=0x06, 2=0x5B, 3=0x4F, 4=0x66, 5=0x6D, 6=0x7D, 7=0x07, 8=0x7F, 9=0x6F. Non-BCD values map to 0x00.
- Line timing (each step lasts TM_DIV clocks):
  - START: tm_clk=1, tm_din 1→0, hold.
  - Each bit: tm_clk=0 with tm_din=bit, hold; then tm_clk=1, hold. Bits go LSB first; the slave samples on tm_clk rising edge.
  - STOP: tm_clk=0, tm_din=0, hold; tm_clk=1, hold; tm_din=1, hold.
  - tm_din never changes while tm_clk=1, except for START/STOP edges.
- State machine: IDLE → START → BITS (8 per byte, loop over bytes in the transaction) → STOP → next transaction's START, or IDLE after T3.
- Frame length: 12 bytes, ≈ 12·16·TM_DIV + 3·4·TM_DIV clocks. This is far below one tick period at the defaults.

Test Plan:
- Reset held low, then released → tm_clk=tm_din=1 during reset. First frame decodes as [9999] - [0000]. Bytes in order: 0x40, 0xC0, 0x6F×4, 0x40, 0x3F×4, 0x8F.
- CLK_FREQ=100_000, run 10_000 clocks past release → u=0001, d=9998. Frame displays [9998] - [0001]. debug_led=1.
- Run 10 ticks → u=0010, d=9989; exercises BCD carry and borrow on the tens digit.
- Preload u=9999, d=0000, then one tick → u=0000, d=9999 (wrap both directions).
- Protocol check over a full frame → exactly 3 START/STOP pairs. No DIN change while CLK high except START/STOP. Each byte is 8 rising CLK edges, LSB first.
- Assert rst low mid-frame → lines go high immediately, counters reload. A fresh complete frame follows release.
